// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: major opcodes, canonical NOP, fetch FSM states.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    // Decoder sees an all-zero opcode whenever the slot is empty.
    function automatic logic [6:0] gated_op(input logic vld, input logic [6:0] opc);
        return vld ? opc : 7'b0000000;
    endfunction

endpackage

// File: rtl/fetch_slot.sv
// Single-entry instruction/PC buffer; a load lands the cycle after it is presented.
// Flush beats load beats consume; contents hold while neither load nor consume occurs.
module fetch_slot
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    input  logic            consume,
    input  logic            flush,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= XLEN'(NOP_INSTR);
            pc_q    <= RESET_PC;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/ready, one-entry output slot; zero-wait memory gives 1 instr/cycle.
// Stall holds the slot and withholds new requests; FETCH_MISALIGN_CHK_EN adds a sticky misalignment halt.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic            fetch_misaligned,
`endif
    output logic [6:0]      op
);

    localparam logic [XLEN-1:0] RST_PC     = XLEN'(RESET_PC);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_fetch_q, pc_fetch_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic            req_pend_q, req_pend_d;

    logic [XLEN-1:0] redirect_tgt;
    logic            fire;
    logic            load;
    logic            consume;

`ifdef FETCH_MISALIGN_CHK_EN
    logic            misaligned_q, misaligned_d;
    logic            misalign_hit;

    assign redirect_tgt = redirect_pc;
    assign misalign_hit = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_tgt = redirect_pc & ALIGN_MASK;
`endif

    assign fire    = imem_req && imem_ready;
    assign consume = instr_valid && !stall;
    // Any redirect, including one landing with imem_ready, throws the response away.
    assign load    = (state_q == FETCH) && fire && !redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_fetch_q   <= RST_PC;
            drop_addr_q  <= RST_PC;
            req_pend_q   <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_fetch_q   <= pc_fetch_d;
            drop_addr_q  <= drop_addr_d;
            req_pend_q   <= req_pend_d;
`ifdef FETCH_MISALIGN_CHK_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_fetch_d   = pc_fetch_q;
        drop_addr_d  = drop_addr_q;
        req_pend_d   = req_pend_q;
`ifdef FETCH_MISALIGN_CHK_EN
        misaligned_d = misaligned_q;
`endif
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_fetch_d = redirect_tgt;
                    req_pend_d = 1'b0;
                    if (imem_req && !imem_ready) begin
                        state_d     = DROP;
                        drop_addr_d = pc_fetch_q;
                    end
                end else if (fire) begin
                    pc_fetch_d = pc_fetch_q + XLEN'(4);
                    req_pend_d = 1'b0;
                end else if (imem_req) begin
                    req_pend_d = 1'b1;
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_fetch_d = redirect_tgt;
                end
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
`ifdef FETCH_MISALIGN_CHK_EN
        if (misalign_hit) begin
            state_d      = HALT;
            misaligned_d = 1'b1;
            req_pend_d   = 1'b0;
        end
`endif
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_fetch_q;
        if (!reset) begin
            case (state_q)
                FETCH: imem_req = req_pend_q || !instr_valid || !stall;
                DROP: begin
                    imem_req  = 1'b1;
                    imem_addr = drop_addr_q;
                end
                default: imem_req = 1'b0;
            endcase
        end
    end

    fetch_slot #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC)
    ) u_slot (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_instr  (imem_rdata),
        .load_pc     (pc_fetch_q),
        .consume     (consume),
        .flush       (redirect),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc)
    );

    assign pc_plus4 = pc + XLEN'(4);
    assign op       = gated_op(instr_valid, instr[6:0]);

`ifdef FETCH_MISALIGN_CHK_EN
    assign fetch_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [6:0]  op;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misaligned;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .XLEN     (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_misaligned (fetch_misaligned),
`endif
        .op               (op)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick();
        #1;
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_pc", pc, 32'h0);
        check("rst_op", {25'b0, op}, 32'h0);
        tick();

        // zero-wait back-to-back fetch
        reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
        #1;
        check("a_req", {31'b0, imem_req}, 32'h1);
        check("a_addr", imem_addr, 32'h0);
        tick();
        imem_rdata = 32'h00a0_0113;
        #1;
        check("b_valid", {31'b0, instr_valid}, 32'h1);
        check("b_instr", instr, 32'h0050_0093);
        check("b_op", {25'b0, op}, 32'h13);
        check("b_pc4", pc_plus4, 32'h4);
        check("b_addr", imem_addr, 32'h4);
        check("b_req", {31'b0, imem_req}, 32'h1);
        tick();

        // three stall cycles with the slot full
        stall = 1'b1; imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_req", {31'b0, imem_req}, 32'h0);
            check("stall_instr", instr, 32'h00a0_0113);
            check("stall_pc", pc, 32'h4);
            check("stall_pc4", pc_plus4, 32'h8);
            tick();
        end
        stall = 1'b0;
        #1;
        check("resume_req", {31'b0, imem_req}, 32'h1);
        check("resume_addr", imem_addr, 32'h8);
        tick();

        // redirect while the 0x8 request waits
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        check("e_req", {31'b0, imem_req}, 32'h1);
        check("e_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("drop_req", {31'b0, imem_req}, 32'h1);
            check("drop_addr", imem_addr, 32'h8);
            tick();
        end
        imem_ready = 1'b1; imem_rdata = 32'hdead_beef;
        #1;
        check("drop_done_addr", imem_addr, 32'h8);
        tick();
        imem_rdata = 32'h0000_0033;
        #1;
        check("i_valid", {31'b0, instr_valid}, 32'h0);
        check("i_addr", imem_addr, 32'h40);
        check("i_req", {31'b0, imem_req}, 32'h1);
        tick();

        // redirect coinciding with imem_ready
        imem_rdata = 32'h0ff0_0093; redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        check("j_pc", pc, 32'h40);
        check("j_op", {25'b0, op}, 32'h33);
        check("j_addr", imem_addr, 32'h44);
        tick();
        redirect = 1'b0; imem_rdata = 32'h0000_0037;
        #1;
        check("k_valid", {31'b0, instr_valid}, 32'h0);
        check("k_op", {25'b0, op}, 32'h0);
        check("k_addr", imem_addr, 32'h100);
        tick();

        // wrap at the top of the address space
        imem_ready = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hffff_fffc;
        #1;
        check("l_pc", pc, 32'h100);
        check("l_op", {25'b0, op}, 32'h37);
        check("l_req", {31'b0, imem_req}, 32'h0);
        tick();
        stall = 1'b0; redirect = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_006f;
        #1;
        check("m_addr", imem_addr, 32'hffff_fffc);
        tick();
        stall = 1'b1; imem_ready = 1'b0;
        #1;
        check("n_pc", pc, 32'hffff_fffc);
        check("n_pc4", pc_plus4, 32'h0);
        check("n_op", {25'b0, op}, 32'h6f);
        check("n_req", {31'b0, imem_req}, 32'h0);
        stall = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_0003;
        #1;
        check("wrap_addr", imem_addr, 32'h0);
        tick();

        // misaligned redirect target
        stall = 1'b1; imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h102;
        #1;
        check("o_pc", pc, 32'h0);
        check("o_op", {25'b0, op}, 32'h03);
        tick();
        redirect = 1'b0; stall = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        for (int i = 0; i < 3; i++) begin
            #1;
            check("halt_flag", {31'b0, fetch_misaligned}, 32'h1);
            check("halt_req", {31'b0, imem_req}, 32'h0);
            check("halt_op", {25'b0, op}, 32'h0);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("unhalt_flag", {31'b0, fetch_misaligned}, 32'h0);
        check("unhalt_req", {31'b0, imem_req}, 32'h1);
        check("unhalt_addr", imem_addr, 32'h0);
`else
        imem_ready = 1'b1; imem_rdata = 32'h0000_0023;
        #1;
        check("align_req", {31'b0, imem_req}, 32'h1);
        check("align_addr", imem_addr, 32'h100);
        tick();
        imem_ready = 1'b0;
        #1;
        check("align_pc", pc, 32'h100);
        check("align_op", {25'b0, op}, 32'h23);
        tick();
        reset = 1'b1;
        #1;
        check("rst_abandon_req", {31'b0, imem_req}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_valid", {31'b0, instr_valid}, 32'h0);
        check("post_rst_addr", imem_addr, 32'h0);
        check("post_rst_req", {31'b0, imem_req}, 32'h1);
`endif
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
